// File: rtl/laoc2_pkg.sv
// Shared definitions for the issue stage: opcodes, reservation-station
// classes and masks, FSM states and the operand-resolution helper.
package laoc2_pkg;

  localparam int DATA_W = 16;
  localparam int N_REG  = 8;
  localparam int REG_AW = 3;
  localparam int TAG_W  = 3;
  localparam int N_RS   = 7;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;

  // Free-bit masks per class; bit i of RS_Livre corresponds to tag i+1.
  localparam logic [N_RS-1:0] RS_MASK_ADD = 7'b0000111;  // tags 1..3
  localparam logic [N_RS-1:0] RS_MASK_MUL = 7'b0011000;  // tags 4..5
  localparam logic [N_RS-1:0] RS_MASK_LS  = 7'b1100000;  // tags 6..7

  typedef enum logic [1:0] {
    CL_NONE,
    CL_ADD,
    CL_MUL,
    CL_LS
  } rs_classe_t;

  typedef enum logic [1:0] {
    BUSCA,
    POP,
    CAPTURA,
    EMITE
  } estado_t;

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
  } operando_t;

  // Unknown opcodes fall into CL_NONE and are handled like NOP.
  function automatic rs_classe_t classe_de(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: classe_de = CL_ADD;
      OP_MUL:         classe_de = CL_MUL;
      OP_LD, OP_ST:   classe_de = CL_LS;
      OP_NOP:         classe_de = CL_NONE;
      default:        classe_de = CL_NONE;
    endcase
  endfunction

  function automatic logic [N_RS-1:0] mascara_de(input rs_classe_t c);
    case (c)
      CL_ADD:  mascara_de = RS_MASK_ADD;
      CL_MUL:  mascara_de = RS_MASK_MUL;
      CL_LS:   mascara_de = RS_MASK_LS;
      default: mascara_de = '0;
    endcase
  endfunction

  // A pending producer whose result is on the CDB this cycle is forwarded
  // immediately; status 0 never matches since the CDB tag is only compared
  // against a nonzero producer.
  function automatic operando_t resolve_operando(
    input logic [TAG_W-1:0]  status,
    input logic [DATA_W-1:0] rf_dado,
    input logic              cdb_valido,
    input logic [TAG_W-1:0]  cdb_tag,
    input logic [DATA_W-1:0] cdb_dado
  );
    operando_t r;
    if (status == '0) begin
      r.v = rf_dado;
      r.q = '0;
    end else if (cdb_valido && (cdb_tag == status)) begin
      r.v = cdb_dado;
      r.q = '0;
    end else begin
      r.v = '0;
      r.q = status;
    end
    return r;
  endfunction

endpackage

// File: rtl/tabela_status_reg.sv
// Register status table: one producer tag per architectural register.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_raddr_a/b, o_rtag_a/b two combinational read ports
//   i_we, i_waddr, i_wtag   rename write port
//   i_cdb_valido, i_cdb_tag CDB broadcast; matching entries clear to 0
module tabela_status_reg
  import laoc2_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [TAG_W-1:0]  o_rtag_a,
  output logic [TAG_W-1:0]  o_rtag_b,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic              i_cdb_valido,
  input  logic [TAG_W-1:0]  i_cdb_tag
);

  logic [N_REG-1:0][TAG_W-1:0] r_status;

  assign o_rtag_a = r_status[i_raddr_a];
  assign o_rtag_b = r_status[i_raddr_b];

  // A rename in the same cycle as a CDB clear of that entry keeps the new tag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status <= '0;
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        if (i_we && (i_waddr == REG_AW'(i))) begin
          r_status[i] <= i_wtag;
        end else if (i_cdb_valido && (i_cdb_tag != '0) && (r_status[i] == i_cdb_tag)) begin
          r_status[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/unidade_de_emissao.sv
// Issue stage: pops instructions from the queue, decodes them, waits for a
// free reservation station of the right class, resolves operands through
// the register status table (with CDB forwarding) and renames Rx.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_instrucao, i_fila_vazia instruction queue data and empty flag
//   o_pop                     one-cycle pop request
//   i_rs_livre                free bit per RS (bit i = tag i+1)
//   o_rf_addr_a/b, i_rf_dado_a/b  register file read (Ry, Rz)
//   i_cdb_valido/tag/dado     common data bus
//   o_emite, o_emite_*        registered issue strobe and fields
//   o_parado                  stalled waiting for a free RS
module unidade_de_emissao
  import laoc2_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_instrucao,
  input  logic              i_fila_vazia,
  output logic              o_pop,
  input  logic [N_RS-1:0]   i_rs_livre,
  output logic [REG_AW-1:0] o_rf_addr_a,
  output logic [REG_AW-1:0] o_rf_addr_b,
  input  logic [DATA_W-1:0] i_rf_dado_a,
  input  logic [DATA_W-1:0] i_rf_dado_b,
  input  logic              i_cdb_valido,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_dado,
  output logic              o_emite,
  output logic [TAG_W-1:0]  o_emite_tag,
  output logic [3:0]        o_emite_op,
  output logic [DATA_W-1:0] o_emite_vj,
  output logic [DATA_W-1:0] o_emite_vk,
  output logic [TAG_W-1:0]  o_emite_qj,
  output logic [TAG_W-1:0]  o_emite_qk,
  output logic              o_parado
);

  estado_t           r_estado, w_prox;
  logic [DATA_W-1:0] r_ir;

  logic              r_emite;
  logic [TAG_W-1:0]  r_emite_tag;
  logic [3:0]        r_emite_op;
  logic [DATA_W-1:0] r_emite_vj, r_emite_vk;
  logic [TAG_W-1:0]  r_emite_qj, r_emite_qk;

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_rx, w_ry, w_rz;
  logic [TAG_W-1:0]  w_stat_a, w_stat_b;
  logic [N_RS-1:0]   w_livres;
  logic              w_tem_livre;
  logic [TAG_W-1:0]  w_tag_livre;
  logic              w_emitir;
  logic              w_renomear;
  operando_t         w_opnd_j, w_opnd_k;
  logic              w_unused_bits;

  assign w_op = r_ir[15:12];
  assign w_rx = r_ir[11:9];
  assign w_ry = r_ir[8:6];
  assign w_rz = r_ir[5:3];
  assign w_unused_bits = ^i_instrucao[2:0];

  assign o_rf_addr_a = w_ry;
  assign o_rf_addr_b = w_rz;

  assign w_livres    = i_rs_livre & mascara_de(classe_de(w_op));
  assign w_tem_livre = |w_livres;
  assign w_emitir    = (r_estado == EMITE) && w_tem_livre;
  assign w_renomear  = w_emitir && (w_op != OP_ST);

  assign w_opnd_j = resolve_operando(w_stat_a, i_rf_dado_a, i_cdb_valido, i_cdb_tag, i_cdb_dado);
  assign w_opnd_k = resolve_operando(w_stat_b, i_rf_dado_b, i_cdb_valido, i_cdb_tag, i_cdb_dado);

  tabela_status_reg u_status (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_raddr_a   (w_ry),
    .i_raddr_b   (w_rz),
    .o_rtag_a    (w_stat_a),
    .o_rtag_b    (w_stat_b),
    .i_we        (w_renomear),
    .i_waddr     (w_rx),
    .i_wtag      (w_tag_livre),
    .i_cdb_valido(i_cdb_valido),
    .i_cdb_tag   (i_cdb_tag)
  );

  // Lowest free tag of the class: scan downward so the lowest set bit wins.
  always_comb begin
    w_tag_livre = '0;
    for (int i = N_RS - 1; i >= 0; i--) begin
      if (w_livres[i]) w_tag_livre = TAG_W'(i + 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_estado <= BUSCA;
    else          r_estado <= w_prox;
  end

  // Pop is a decode of the POP state so it is high for exactly one full
  // cycle, letting the queue see it on the mid-cycle negedge.
  always_comb begin
    w_prox   = r_estado;
    o_pop    = 1'b0;
    o_parado = 1'b0;
    case (r_estado)
      BUSCA: begin
        if (!i_fila_vazia) w_prox = POP;
      end
      POP: begin
        o_pop  = 1'b1;
        w_prox = CAPTURA;
      end
      CAPTURA: begin
        if (classe_de(i_instrucao[15:12]) == CL_NONE) w_prox = BUSCA;
        else                                          w_prox = EMITE;
      end
      EMITE: begin
        if (w_tem_livre) w_prox   = BUSCA;
        else             o_parado = 1'b1;
      end
      default: w_prox = BUSCA;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ir        <= '0;
      r_emite     <= 1'b0;
      r_emite_tag <= '0;
      r_emite_op  <= '0;
      r_emite_vj  <= '0;
      r_emite_vk  <= '0;
      r_emite_qj  <= '0;
      r_emite_qk  <= '0;
    end else begin
      if (r_estado == CAPTURA) r_ir <= i_instrucao;
      r_emite <= w_emitir;
      if (w_emitir) begin
        r_emite_tag <= w_tag_livre;
        r_emite_op  <= w_op;
        r_emite_vj  <= w_opnd_j.v;
        r_emite_vk  <= w_opnd_k.v;
        r_emite_qj  <= w_opnd_j.q;
        r_emite_qk  <= w_opnd_k.q;
      end
    end
  end

  assign o_emite     = r_emite;
  assign o_emite_tag = r_emite_tag;
  assign o_emite_op  = r_emite_op;
  assign o_emite_vj  = r_emite_vj;
  assign o_emite_vk  = r_emite_vk;
  assign o_emite_qj  = r_emite_qj;
  assign o_emite_qk  = r_emite_qk;

endmodule

// File: tb/tb_unidade_de_emissao.sv
// Testbench for unidade_de_emissao: queue and register file models, and a
// transaction-level reference model of the register status table.
module tb_unidade_de_emissao;

  logic        clk;
  logic        rst_n;
  logic [15:0] instrucao;
  logic        fila_vazia;
  logic        pop;
  logic [6:0]  rs_livre;
  logic [2:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_dado_a, rf_dado_b;
  logic        cdb_valido;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_dado;
  logic        emite;
  logic [2:0]  emite_tag;
  logic [3:0]  emite_op;
  logic [15:0] emite_vj, emite_vk;
  logic [2:0]  emite_qj, emite_qk;
  logic        parado;

  logic [15:0] q[$];
  logic [15:0] exp_q[$];
  logic [2:0]  mstat[8];
  logic [15:0] rf_mem[8];
  int          vecs;
  int          fails;
  bit          saw_emite;

  assign rf_dado_a = rf_mem[rf_addr_a];
  assign rf_dado_b = rf_mem[rf_addr_b];

  unidade_de_emissao dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_instrucao (instrucao),
    .i_fila_vazia(fila_vazia),
    .o_pop       (pop),
    .i_rs_livre  (rs_livre),
    .o_rf_addr_a (rf_addr_a),
    .o_rf_addr_b (rf_addr_b),
    .i_rf_dado_a (rf_dado_a),
    .i_rf_dado_b (rf_dado_b),
    .i_cdb_valido(cdb_valido),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_dado  (cdb_dado),
    .o_emite     (emite),
    .o_emite_tag (emite_tag),
    .o_emite_op  (emite_op),
    .o_emite_vj  (emite_vj),
    .o_emite_vk  (emite_vk),
    .o_emite_qj  (emite_qj),
    .o_emite_qk  (emite_qk),
    .o_parado    (parado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Which RS tags serve an opcode: ADD/SUB 1..3, MUL 4..5, LD/ST 6..7.
  function automatic logic [6:0] class_mask(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return 7'b0000111;
      4'd3:       return 7'b0011000;
      4'd4, 4'd5: return 7'b1100000;
      default:    return 7'b0000000;
    endcase
  endfunction

  function automatic logic [15:0] mk(input int op, input int rx, input int ry, input int rz);
    logic [15:0] r;
    r = {op[3:0], rx[2:0], ry[2:0], rz[2:0], 3'b000};
    return r;
  endfunction

  function automatic logic [7:0][2:0] model_packed();
    logic [7:0][2:0] p;
    for (int i = 0; i < 8; i++) p[i] = mstat[i];
    return p;
  endfunction

  task automatic push(input logic [15:0] ins);
    q.push_back(ins);
    fila_vazia = 1'b0;
    if (class_mask(ins[15:12]) != 7'b0) exp_q.push_back(ins);
  endtask

  task automatic model_clear();
    q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) mstat[i] = 3'd0;
  endtask

  // One clock: observe at the negedge, check any issue against the model,
  // advance the model, then let the queue answer a pop.
  task automatic tick();
    logic [15:0] e;
    logic [6:0]  fr;
    int          etag;
    logic [2:0]  s;
    logic [15:0] evj, evk;
    logic [2:0]  eqj, eqk;
    @(negedge clk);
    saw_emite = emite;
    etag = 0;
    e = 16'h0;
    if (emite) begin
      vecs++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL spurious_issue got tag=%0d op=%0d, expected no issue", emite_tag, emite_op);
      end else begin
        e = exp_q.pop_front();
        fr = rs_livre & class_mask(e[15:12]);
        for (int i = 6; i >= 0; i--) if (fr[i]) etag = i + 1;
        s = mstat[e[8:6]];
        if (s == 0) begin evj = rf_mem[e[8:6]]; eqj = 0; end
        else if (cdb_valido && cdb_tag == s) begin evj = cdb_dado; eqj = 0; end
        else begin evj = 0; eqj = s; end
        s = mstat[e[5:3]];
        if (s == 0) begin evk = rf_mem[e[5:3]]; eqk = 0; end
        else if (cdb_valido && cdb_tag == s) begin evk = cdb_dado; eqk = 0; end
        else begin evk = 0; eqk = s; end
        if ({emite_tag, emite_op, emite_vj, emite_vk, emite_qj, emite_qk} !==
            {etag[2:0], e[15:12], evj, evk, eqj, eqk}) begin
          fails++;
          $display("[TB] FAIL issue_fields got tag=%0d op=%0d vj=%h vk=%h qj=%0d qk=%0d, expected tag=%0d op=%0d vj=%h vk=%h qj=%0d qk=%0d",
                   emite_tag, emite_op, emite_vj, emite_vk, emite_qj, emite_qk,
                   etag, e[15:12], evj, evk, eqj, eqk);
        end
      end
    end
    if (cdb_valido && cdb_tag != 0)
      for (int i = 0; i < 8; i++) if (mstat[i] == cdb_tag) mstat[i] = 3'd0;
    if (emite && etag != 0 && e[15:12] != 4'd5) mstat[e[11:9]] = etag[2:0];
    if (parado) begin
      vecs++;
      if (exp_q.size() == 0 || (rs_livre & class_mask(exp_q[0][15:12])) != 7'b0) begin
        fails++;
        $display("[TB] FAIL stall_reason got parado=1 with rs_livre=%b, expected parado=0", rs_livre);
      end
    end
    if (pop && q.size() > 0) instrucao = q.pop_front();
    fila_vazia = (q.size() == 0);
  endtask

  task automatic wait_emite(input int budget);
    int n;
    n = 0;
    saw_emite = 1'b0;
    while (!saw_emite && n < budget) begin tick(); n++; end
    vecs++;
    if (!saw_emite) begin
      fails++;
      $display("[TB] FAIL issue_timeout got no issue in %0d cycles, expected an issue", budget);
    end
  endtask

  task automatic wait_parado(input int budget);
    int n;
    n = 0;
    while (!parado && n < budget) begin tick(); n++; end
    vecs++;
    if (!parado) begin
      fails++;
      $display("[TB] FAIL stall_timeout got parado=0 after %0d cycles, expected 1", budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    fila_vazia = 1'b1;
    instrucao  = 16'h0;
    cdb_valido = 1'b0;
    cdb_tag    = 3'd0;
    cdb_dado   = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_status(input string name, input int idx, input logic [2:0] expv);
    vecs++;
    if (dut.u_status.r_status[idx] !== expv) begin
      fails++;
      $display("[TB] FAIL %s got status[%0d]=%0d, expected %0d", name, idx, dut.u_status.r_status[idx], expv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rs_livre = 7'h7F;
    model_clear();
    fila_vazia = 1'b1;
    instrucao = 16'h0;
    cdb_valido = 1'b0; cdb_tag = 0; cdb_dado = 0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({emite, pop, parado, emite_tag, emite_op, emite_vj, emite_vk, emite_qj, emite_qk, rf_addr_a, rf_addr_b} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got nonzero outputs emite=%b pop=%b parado=%b, expected all 0", emite, pop, parado);
    end
    rst_n = 1'b1;
    rs_livre = 7'b1111000;
    push(mk(1, 1, 2, 3));
    wait_parado(10);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({emite, pop, parado} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_mid_emite got emite=%b pop=%b parado=%b, expected 000", emite, pop, parado);
    end
    vecs++;
    if (dut.u_status.r_status !== '0) begin
      fails++;
      $display("[TB] FAIL reset_status got %h, expected 0", dut.u_status.r_status);
    end
    model_clear();
    fila_vazia = 1'b1;
    instrucao = 16'h0;
    rs_livre = 7'h7F;
    @(negedge clk);
    rst_n = 1'b1;
    saw_emite = 1'b0;
    begin
      bit any;
      any = 1'b0;
      repeat (6) begin tick(); if (pop || emite || parado) any = 1'b1; end
      vecs++;
      if (any) begin
        fails++;
        $display("[TB] FAIL reset_restart got activity after reset, expected idle in BUSCA");
      end
    end
  endtask

  task automatic test_empty_pop();
    int npops;
    bit seen;
    seen = 1'b0;
    fila_vazia = 1'b1;
    repeat (6) begin tick(); if (pop) seen = 1'b1; end
    vecs++;
    if (seen) begin
      fails++;
      $display("[TB] FAIL pop_when_empty got pop=1, expected 0");
    end
    rs_livre = 7'h7F;
    push(mk(1, 5, 6, 7));
    npops = 0;
    saw_emite = 1'b0;
    for (int i = 0; i < 12 && !saw_emite; i++) begin tick(); if (pop) npops++; end
    vecs++;
    if (npops != 1 || !saw_emite) begin
      fails++;
      $display("[TB] FAIL pop_pulse got pops=%0d issued=%b, expected pops=1 issued=1", npops, saw_emite);
    end
  endtask

  task automatic test_add();
    do_reset();
    rs_livre = 7'h7F;
    push(mk(1, 1, 2, 3));
    wait_emite(10);
    vecs++;
    if ({emite_tag, emite_qj, emite_qk, emite_vj, emite_vk} !== {3'd1, 3'd0, 3'd0, rf_mem[2], rf_mem[3]}) begin
      fails++;
      $display("[TB] FAIL add_issue got tag=%0d qj=%0d qk=%0d vj=%h vk=%h, expected tag=1 qj=0 qk=0 vj=%h vk=%h",
               emite_tag, emite_qj, emite_qk, emite_vj, emite_vk, rf_mem[2], rf_mem[3]);
    end
    check_status("add_rename", 1, 3'd1);
  endtask

  task automatic test_mul();
    push(mk(3, 4, 1, 1));
    wait_emite(10);
    vecs++;
    if ({emite_tag, emite_qj, emite_qk, emite_vj, emite_vk} !== {3'd4, 3'd1, 3'd1, 16'h0, 16'h0}) begin
      fails++;
      $display("[TB] FAIL mul_issue got tag=%0d qj=%0d qk=%0d vj=%h vk=%h, expected tag=4 qj=1 qk=1 vj=0 vk=0",
               emite_tag, emite_qj, emite_qk, emite_vj, emite_vk);
    end
    cdb_valido = 1'b1; cdb_tag = 3'd1; cdb_dado = 16'($urandom);
    tick();
    cdb_valido = 1'b0;
    check_status("cdb_clear", 1, 3'd0);
    check_status("cdb_keep", 4, 3'd4);
  endtask

  task automatic test_forward();
    rs_livre = 7'b1111110;
    push(mk(1, 2, 0, 0));
    wait_emite(10);
    vecs++;
    if (emite_tag !== 3'd2) begin
      fails++;
      $display("[TB] FAIL fwd_setup got tag=%0d, expected 2", emite_tag);
    end
    rs_livre = 7'b1111000;
    push(mk(2, 3, 2, 5));
    wait_parado(10);
    rs_livre = 7'h7F;
    cdb_valido = 1'b1; cdb_tag = 3'd2; cdb_dado = 16'h00AA;
    tick();
    cdb_valido = 1'b0;
    vecs++;
    if (!saw_emite || {emite_vj, emite_qj, emite_tag, emite_vk} !== {16'h00AA, 3'd0, 3'd1, rf_mem[5]}) begin
      fails++;
      $display("[TB] FAIL forward got issued=%b vj=%h qj=%0d tag=%0d vk=%h, expected issued=1 vj=00aa qj=0 tag=1 vk=%h",
               saw_emite, emite_vj, emite_qj, emite_tag, emite_vk, rf_mem[5]);
    end
    check_status("fwd_cleared", 2, 3'd0);
    check_status("fwd_rename", 3, 3'd1);
  endtask

  task automatic test_stall();
    bit bad;
    rs_livre = 7'b1111000;
    push(mk(1, 6, 7, 7));
    wait_parado(10);
    bad = 1'b0;
    repeat (3) begin tick(); if (emite || !parado) bad = 1'b1; end
    vecs++;
    if (bad) begin
      fails++;
      $display("[TB] FAIL stall_hold got issue or parado drop while no ADD RS free, expected parado=1 no issue");
    end
    rs_livre = 7'b1111010;
    tick();
    vecs++;
    if (!saw_emite || emite_tag !== 3'd2) begin
      fails++;
      $display("[TB] FAIL stall_release got issued=%b tag=%0d, expected issued=1 tag=2", saw_emite, emite_tag);
    end
  endtask

  task automatic test_nop();
    logic [7:0][2:0] snap;
    bit any;
    snap = model_packed();
    rs_livre = 7'h7F;
    push(16'h0000);
    push(16'hF123);
    any = 1'b0;
    repeat (12) begin tick(); if (emite || parado) any = 1'b1; end
    vecs++;
    if (any) begin
      fails++;
      $display("[TB] FAIL nop_issue got issue/stall for NOP, expected none");
    end
    vecs++;
    if (dut.u_status.r_status !== snap) begin
      fails++;
      $display("[TB] FAIL nop_status got %h, expected %h", dut.u_status.r_status, snap);
    end
    push(mk(1, 0, 1, 2));
    wait_emite(10);
  endtask

  task automatic test_random();
    int pushed;
    int guard;
    int r;
    do_reset();
    pushed = 0;
    guard = 0;
    while ((pushed < 60 || exp_q.size() > 0 || q.size() > 0) && guard < 4000) begin
      if (pushed < 60 && q.size() < 2) begin
        push(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
        pushed++;
      end
      rs_livre = 7'($urandom);
      cdb_valido = 1'($urandom);
      r = $urandom_range(0, 7);
      cdb_tag = ($urandom_range(0, 1) != 0) ? mstat[r] : 3'($urandom_range(0, 7));
      cdb_dado = 16'($urandom);
      tick();
      vecs++;
      if (dut.u_status.r_status !== model_packed()) begin
        fails++;
        $display("[TB] FAIL random_status got %h, expected %h", dut.u_status.r_status, model_packed());
      end
      guard++;
    end
    cdb_valido = 1'b0;
    vecs++;
    if (guard >= 4000) begin
      fails++;
      $display("[TB] FAIL random_drain got %0d instructions pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    vecs = 0;
    fails = 0;
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'($urandom);
    test_reset();
    test_empty_pop();
    test_add();
    test_mul();
    test_forward();
    test_stall();
    test_nop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
